// File: rtl/qpu_oitf_pkg.sv
// qpu_oitf_pkg: default sizes and width helpers for the outstanding-instruction tracker
package qpu_oitf_pkg;
  localparam int OITF_DEPTH_DEF = 4;
  localparam int RFIDX_W_DEF = 5;
  localparam int QUBIT_NUM_DEF = 12;
  localparam int MF_DEPTH_DEF = 4;
  localparam int QCNT_W_DEF = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) if ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int occ_w(input int depth);
    return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/qpu_exu_oitf_mq_if.sv
// qpu_exu_oitf_mq_if: dispatch/retire bundle of the tracker; slave is the tracker side
interface qpu_exu_oitf_mq_if
  import qpu_oitf_pkg::*;
#(
  parameter int OITF_DEPTH = OITF_DEPTH_DEF,
  parameter int RFIDX_W = RFIDX_W_DEF,
  parameter int QUBIT_NUM = QUBIT_NUM_DEF,
  localparam int CW = occ_w(OITF_DEPTH)
);
  logic dis_cl_ena;
  logic dis_cf_ready;
  logic disp_i_rdwen;
  logic [RFIDX_W-1:0] disp_i_rdidx;
  logic disp_i_rs1en;
  logic [RFIDX_W-1:0] disp_i_rs1idx;
  logic disp_i_rs2en;
  logic [RFIDX_W-1:0] disp_i_rs2idx;
  logic ret_cl_ena;
  logic [RFIDX_W-1:0] ret_rdidx;
  logic ret_rdwen;
  logic oitfrd_match_disprs1;
  logic oitfrd_match_disprs2;
  logic oitfrd_match_disprd;
  logic oitf_empty;
  logic [CW-1:0] oitf_cnt;
  logic dis_qf_ena;
  logic dis_mf_ready;
  logic [QUBIT_NUM-1:0] disp_i_ql;
  logic disp_i_qfren;
  logic ret_qf_ena;
  logic [QUBIT_NUM-1:0] ret_mf;
  logic moitf_empty;
  logic oitfqf_match_dispql;
  logic [QUBIT_NUM-1:0] qf_busy;
  modport slave (
    input dis_cl_ena, disp_i_rdwen, disp_i_rdidx, disp_i_rs1en, disp_i_rs1idx,
    input disp_i_rs2en, disp_i_rs2idx, ret_cl_ena, dis_qf_ena, disp_i_ql, disp_i_qfren, ret_qf_ena,
    output dis_cf_ready, ret_rdidx, ret_rdwen, oitfrd_match_disprs1, oitfrd_match_disprs2,
    output oitfrd_match_disprd, oitf_empty, oitf_cnt, dis_mf_ready, ret_mf, moitf_empty,
    output oitfqf_match_dispql, qf_busy
  );
  modport master (
    output dis_cl_ena, disp_i_rdwen, disp_i_rdidx, disp_i_rs1en, disp_i_rs1idx,
    output disp_i_rs2en, disp_i_rs2idx, ret_cl_ena, dis_qf_ena, disp_i_ql, disp_i_qfren, ret_qf_ena,
    input dis_cf_ready, ret_rdidx, ret_rdwen, oitfrd_match_disprs1, oitfrd_match_disprs2,
    input oitfrd_match_disprd, oitf_empty, oitf_cnt, dis_mf_ready, ret_mf, moitf_empty,
    input oitfqf_match_dispql, qf_busy
  );
endinterface

// File: rtl/qpu_gnrl_ring_ptr.sv
// qpu_gnrl_ring_ptr: circular index 0..DEPTH-1 with a flag that toggles on every wrap
module qpu_gnrl_ring_ptr
  import qpu_oitf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic [PW-1:0] ptr,
  output logic flg
);
  logic [PW-1:0] ptr_q, ptr_d;
  logic flg_q, flg_d, last;
  always_comb begin
    last = (ptr_q == PW'(DEPTH - 1));
    ptr_d = en ? (last ? '0 : ptr_q + 1'b1) : ptr_q;
    flg_d = flg_q ^ (en & last);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      flg_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      flg_q <= flg_d;
    end
  end
  assign ptr = ptr_q;
  assign flg = flg_q;
endmodule

// File: rtl/qpu_exu_oitf_mq.sv
// qpu_exu_oitf_mq: classical rd tracker plus measurement FIFO with per-qubit busy counters.
// Optional QPU_OITF_RET_BYPASS_EN lets a same-cycle retire free a slot for dispatch.
module qpu_exu_oitf_mq
  import qpu_oitf_pkg::*;
#(
  parameter int OITF_DEPTH = OITF_DEPTH_DEF,
  parameter int RFIDX_W = RFIDX_W_DEF,
  parameter int QUBIT_NUM = QUBIT_NUM_DEF,
  parameter int MF_DEPTH = MF_DEPTH_DEF,
  parameter int QCNT_W = QCNT_W_DEF,
  localparam int CW = occ_w(OITF_DEPTH),
  localparam int PW = ptr_w(OITF_DEPTH),
  localparam int MPW = ptr_w(MF_DEPTH)
) (
  input logic clk,
  input logic rst,
  qpu_exu_oitf_mq_if.slave bus
);
  logic [PW-1:0] aptr, rptr;
  logic aflg, rflg, full, empty, cf_ready, alloc, retire;
  logic [MPW-1:0] maptr, mrptr;
  logic maflg, mrflg, mf_full, mf_empty, mf_ready, push, pop;
  logic [OITF_DEPTH-1:0] vld_q, vld_d, rdwen_q, rdwen_d;
  logic [RFIDX_W-1:0] rdidx_q [OITF_DEPTH];
  logic [RFIDX_W-1:0] rdidx_d [OITF_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QUBIT_NUM-1:0] mf_q [MF_DEPTH];
  logic [QUBIT_NUM-1:0] mf_d [MF_DEPTH];
  logic [QUBIT_NUM-1:0] mf_head, busy;
  logic [QCNT_W-1:0] qcnt_q [QUBIT_NUM];
  logic [QCNT_W-1:0] qcnt_d [QUBIT_NUM];
  logic m1, m2, md;
  qpu_gnrl_ring_ptr #(.DEPTH(OITF_DEPTH)) u_cl_aptr (.clk, .rst, .en(alloc), .ptr(aptr), .flg(aflg));
  qpu_gnrl_ring_ptr #(.DEPTH(OITF_DEPTH)) u_cl_rptr (.clk, .rst, .en(retire), .ptr(rptr), .flg(rflg));
  qpu_gnrl_ring_ptr #(.DEPTH(MF_DEPTH)) u_mf_aptr (.clk, .rst, .en(push), .ptr(maptr), .flg(maflg));
  qpu_gnrl_ring_ptr #(.DEPTH(MF_DEPTH)) u_mf_rptr (.clk, .rst, .en(pop), .ptr(mrptr), .flg(mrflg));
  // a single-entry FIFO has no pointer movement to compare, so its valid bit is the truth
  assign full = (OITF_DEPTH == 1) ? vld_q[0] : (aptr == rptr) && (aflg != rflg);
  assign empty = (OITF_DEPTH == 1) ? ~vld_q[0] : (aptr == rptr) && (aflg == rflg);
  assign mf_full = (maptr == mrptr) && (maflg != mrflg);
  assign mf_empty = (maptr == mrptr) && (maflg == mrflg);
`ifdef QPU_OITF_RET_BYPASS_EN
  assign cf_ready = ~full | bus.ret_cl_ena;
  assign mf_ready = ~mf_full | bus.ret_qf_ena;
`else
  assign cf_ready = ~full;
  assign mf_ready = ~mf_full;
`endif
  assign alloc = bus.dis_cl_ena & cf_ready;
  assign retire = bus.ret_cl_ena & ~empty;
  assign push = bus.dis_qf_ena & mf_ready;
  assign pop = bus.ret_qf_ena & ~mf_empty;
  assign mf_head = mf_empty ? '0 : mf_q[mrptr];
  always_comb begin
    vld_d = vld_q;
    rdwen_d = rdwen_q;
    rdidx_d = rdidx_q;
    cnt_d = cnt_q + CW'(alloc) - CW'(retire);
    if (retire) vld_d[rptr] = 1'b0;
    if (alloc) begin
      vld_d[aptr] = 1'b1;
      rdwen_d[aptr] = bus.disp_i_rdwen;
      rdidx_d[aptr] = bus.disp_i_rdidx;
    end
    m1 = 1'b0;
    m2 = 1'b0;
    md = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      m1 |= vld_q[i] & rdwen_q[i] & bus.disp_i_rs1en & (rdidx_q[i] == bus.disp_i_rs1idx);
      m2 |= vld_q[i] & rdwen_q[i] & bus.disp_i_rs2en & (rdidx_q[i] == bus.disp_i_rs2idx);
      md |= vld_q[i] & rdwen_q[i] & bus.disp_i_rdwen & (rdidx_q[i] == bus.disp_i_rdidx);
    end
  end
  always_comb begin
    mf_d = mf_q;
    if (push) mf_d[maptr] = bus.disp_i_ql;
    for (int j = 0; j < QUBIT_NUM; j++) begin
      qcnt_d[j] = (push & bus.disp_i_ql[j] & ~(pop & mf_head[j])) ? qcnt_q[j] + 1'b1 :
                  (pop & mf_head[j] & ~(push & bus.disp_i_ql[j])) ? qcnt_q[j] - 1'b1 : qcnt_q[j];
      busy[j] = (qcnt_q[j] != '0);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      rdwen_q <= '0;
      rdidx_q <= '{default: '0};
      cnt_q <= '0;
      mf_q <= '{default: '0};
      qcnt_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      rdwen_q <= rdwen_d;
      rdidx_q <= rdidx_d;
      cnt_q <= cnt_d;
      mf_q <= mf_d;
      qcnt_q <= qcnt_d;
    end
  end
  assign bus.dis_cf_ready = cf_ready;
  assign bus.ret_rdidx = empty ? '0 : rdidx_q[rptr];
  assign bus.ret_rdwen = ~empty & rdwen_q[rptr];
  assign bus.oitfrd_match_disprs1 = m1;
  assign bus.oitfrd_match_disprs2 = m2;
  assign bus.oitfrd_match_disprd = md;
  assign bus.oitf_empty = empty;
  assign bus.oitf_cnt = cnt_q;
  assign bus.dis_mf_ready = mf_ready;
  assign bus.ret_mf = mf_head;
  assign bus.moitf_empty = mf_empty;
  assign bus.qf_busy = busy;
  assign bus.oitfqf_match_dispql = bus.disp_i_qfren & |(busy & bus.disp_i_ql);
endmodule

// File: tb/tb_qpu_exu_oitf_mq.sv
// tb_qpu_exu_oitf_mq: random and directed traffic checked against a queue-based model
module tb_qpu_exu_oitf_mq;
  localparam int D = 4;
  localparam int MD = 4;
  typedef struct packed {logic w; logic [4:0] rd;} ent_t;
  logic clk = 1'b0, rst = 1'b1;
  int n_cmp = 0, n_err = 0;
  ent_t cq[$];
  logic [11:0] mq[$];
  always #5 clk = ~clk;
  qpu_exu_oitf_mq_if b ();
  qpu_exu_oitf_mq dut (.clk(clk), .rst(rst), .bus(b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic cf_rdy();
`ifdef QPU_OITF_RET_BYPASS_EN
    return (cq.size() < D) || b.ret_cl_ena;
`else
    return cq.size() < D;
`endif
  endfunction
  function automatic logic mf_rdy();
`ifdef QPU_OITF_RET_BYPASS_EN
    return (mq.size() < MD) || b.ret_qf_ena;
`else
    return mq.size() < MD;
`endif
  endfunction
  task automatic check_all();
    logic m1, m2, md;
    logic [11:0] bz;
    m1 = 0; m2 = 0; md = 0; bz = '0;
    foreach (cq[i]) begin
      m1 |= cq[i].w & b.disp_i_rs1en & (cq[i].rd == b.disp_i_rs1idx);
      m2 |= cq[i].w & b.disp_i_rs2en & (cq[i].rd == b.disp_i_rs2idx);
      md |= cq[i].w & b.disp_i_rdwen & (cq[i].rd == b.disp_i_rdidx);
    end
    foreach (mq[i]) bz |= mq[i];
    chk("oitf_empty", 32'(b.oitf_empty), 32'(cq.size() == 0));
    chk("oitf_cnt", 32'(b.oitf_cnt), 32'(cq.size()));
    chk("cf_ready", 32'(b.dis_cf_ready), 32'(cf_rdy()));
    chk("ret_rdidx", 32'(b.ret_rdidx), cq.size() ? 32'(cq[0].rd) : 0);
    chk("ret_rdwen", 32'(b.ret_rdwen), cq.size() ? 32'(cq[0].w) : 0);
    chk("match_rs1", 32'(b.oitfrd_match_disprs1), 32'(m1));
    chk("match_rs2", 32'(b.oitfrd_match_disprs2), 32'(m2));
    chk("match_rd", 32'(b.oitfrd_match_disprd), 32'(md));
    chk("moitf_empty", 32'(b.moitf_empty), 32'(mq.size() == 0));
    chk("mf_ready", 32'(b.dis_mf_ready), 32'(mf_rdy()));
    chk("ret_mf", 32'(b.ret_mf), mq.size() ? 32'(mq[0]) : 0);
    chk("qf_busy", 32'(b.qf_busy), 32'(bz));
    chk("match_ql", 32'(b.oitfqf_match_dispql), 32'(b.disp_i_qfren & |(bz & b.disp_i_ql)));
  endtask
  task automatic cycle();
    logic a, r, p, q;
    #1 check_all();
    a = b.dis_cl_ena & cf_rdy();
    r = b.ret_cl_ena & (cq.size() > 0);
    p = b.dis_qf_ena & mf_rdy();
    q = b.ret_qf_ena & (mq.size() > 0);
    if (r) void'(cq.pop_front());
    if (a) cq.push_back({b.disp_i_rdwen, b.disp_i_rdidx});
    if (q) void'(mq.pop_front());
    if (p) mq.push_back(b.disp_i_ql);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drv(input logic cl, input logic [4:0] rd, input logic rcl, input logic qf,
                     input logic [11:0] ql, input logic rqf, input logic [4:0] rs1, input logic qfr);
    b.dis_cl_ena = cl; b.disp_i_rdwen = 1'b1; b.disp_i_rdidx = rd;
    b.disp_i_rs1en = 1'b1; b.disp_i_rs1idx = rs1; b.disp_i_rs2en = 1'b0; b.disp_i_rs2idx = '0;
    b.ret_cl_ena = rcl; b.dis_qf_ena = qf; b.disp_i_ql = ql; b.ret_qf_ena = rqf; b.disp_i_qfren = qfr;
  endtask
  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    b.disp_i_rdwen = 1'b0;
    b.disp_i_rs1en = 1'b0;
    #12 check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drv(1, 5'(k), 0, 0, 0, 0, 0, 0);
      cycle();
    end
    drv(0, 0, 0, 0, 0, 0, 5'd3, 0);
    #1 chk("full_cnt", 32'(b.oitf_cnt), 4);
    chk("full_rdy", 32'(b.dis_cf_ready), 0);
    chk("rs1_hit3", 32'(b.oitfrd_match_disprs1), 1);
    cycle();
    drv(1, 5'd9, 1, 0, 0, 0, 0, 0);
    cycle();
`ifdef QPU_OITF_RET_BYPASS_EN
    chk("full_alloc_ret_cnt", 32'(b.oitf_cnt), 4);
`else
    chk("full_alloc_ret_cnt", 32'(b.oitf_cnt), 3);
`endif
    for (int k = 0; k < 5; k++) begin
      drv(0, 0, 1, 0, 0, 0, 0, 0);
      cycle();
    end
    chk("drained", 32'(b.oitf_empty), 1);
    drv(0, 0, 0, 1, 12'b101, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 1, 12'b001, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    #1 chk("busy_101", 32'(b.qf_busy), 32'b101);
    cycle();
    drv(0, 0, 0, 0, 12'b001, 0, 0, 1);
    #1 chk("busy_001", 32'(b.qf_busy), 32'b001);
    chk("ql_hit", 32'(b.oitfqf_match_dispql), 1);
    cycle();
    drv(0, 0, 0, 0, 12'b001, 1, 0, 1);
    cycle();
    drv(0, 0, 0, 0, 12'b001, 0, 0, 1);
    #1 chk("ql_clear", 32'(b.oitfqf_match_dispql), 0);
    cycle();
    for (int k = 0; k < 10; k++) begin
      drv(0, 0, 0, 1, 12'b010, k > 0, 0, 0);
      cycle();
    end
    for (int k = 0; k < 400; k++) begin
      b.dis_cl_ena = $urandom_range(0, 2) != 0;
      b.disp_i_rdwen = $urandom_range(0, 3) != 0;
      b.disp_i_rdidx = 5'($urandom_range(0, 7));
      b.disp_i_rs1en = $urandom_range(0, 1) != 0;
      b.disp_i_rs1idx = 5'($urandom_range(0, 7));
      b.disp_i_rs2en = $urandom_range(0, 1) != 0;
      b.disp_i_rs2idx = 5'($urandom_range(0, 7));
      b.ret_cl_ena = $urandom_range(0, 2) == 0;
      b.dis_qf_ena = $urandom_range(0, 2) != 0;
      b.disp_i_ql = 12'($urandom_range(0, 4095)) & 12'h00f;
      b.disp_i_qfren = $urandom_range(0, 1) != 0;
      b.ret_qf_ena = $urandom_range(0, 2) == 0;
      cycle();
    end
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 1, 0, 0, 1, 0, 0);
      cycle();
    end
    for (int k = 0; k < 3; k++) begin
      drv(1, 5'(k + 5), 0, k < 2, 12'(k + 1), 0, 0, 0);
      cycle();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    cq.delete();
    mq.delete();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
